// File: rtl/delay_aligner_pkg.sv
// delay_aligner_pkg: shared state encoding and default sizing for the delay aligner
package delay_aligner_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
  localparam int DA_CNT_W = 4;
  localparam int DA_MAX_DLY = 15;
endpackage

// File: rtl/delay_ring_buf.sv
// delay_ring_buf: always-writing history of ref_in with a tap j samples behind the write pointer
module delay_ring_buf #(
  parameter int Nbits = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Nbits:0]   ref_in,
  input  logic [CNT_W-1:0] j,
  output logic [Nbits:0]   tap
);
  logic [Nbits:0] mem [2**CNT_W];
  logic [CNT_W-1:0] wr_ptr;
  always_ff @(posedge clk)
    wr_ptr <= rst ? '0 : wr_ptr + CNT_W'(1);
  always_ff @(posedge clk)
    mem[wr_ptr] <= ref_in;
  always_comb
    tap = (j == '0) ? ref_in : mem[wr_ptr - j];
endmodule

// File: rtl/delay_aligner.sv
// delay_aligner: measures an external path latency with a marker and re-aligns ref_in to it
module delay_aligner
  import delay_aligner_pkg::*;
#(
  parameter int Nbits = 2,
  parameter int CNT_W = DA_CNT_W,
  parameter int MAX_DLY = DA_MAX_DLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Nbits:0]   ref_in,
  input  logic [Nbits:0]   dly_in,
  output logic [Nbits:0]   ref_out,
  output logic [CNT_W-1:0] latency,
  output logic             locked,
  output logic             timeout,
  output logic             misalign
);
  state_t state, state_nx;
  logic [Nbits:0] marker, marker_nx, ref_out_nx, tap;
  logic [CNT_W-1:0] cnt, cnt_nx, latency_nx, j;
  logic timeout_nx, misalign_nx;
  always_comb
    j = (state == LOCKED ? latency : cnt) - CNT_W'(1);
  delay_ring_buf #(.Nbits(Nbits), .CNT_W(CNT_W)) u_buf (
    .clk(clk),
    .rst(rst),
    .ref_in(ref_in),
    .j(j),
    .tap(tap)
  );
  always_comb begin
    state_nx = state;
    marker_nx = marker;
    cnt_nx = cnt;
    latency_nx = latency;
    timeout_nx = 1'b0;
    if (start) begin
      state_nx = SEARCH;
      marker_nx = ref_in;
      cnt_nx = CNT_W'(1);
    end else if (state == SEARCH) begin
      if (dly_in == marker) begin
        state_nx = LOCKED;
        latency_nx = cnt;
      end else if (cnt == CNT_W'(MAX_DLY)) begin
        state_nx = IDLE;
        timeout_nx = 1'b1;
      end else
        cnt_nx = cnt + CNT_W'(1);
    end
    ref_out_nx = (state_nx == LOCKED) ? tap : '0;
    misalign_nx = !start && state == LOCKED && ref_out != dly_in;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      marker <= '0;
      cnt <= '0;
      latency <= '0;
      ref_out <= '0;
      timeout <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state <= state_nx;
      marker <= marker_nx;
      cnt <= cnt_nx;
      latency <= latency_nx;
      ref_out <= ref_out_nx;
      timeout <= timeout_nx;
      misalign <= misalign_nx;
    end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_delay_aligner.sv
// tb_delay_aligner: directed checks of locking, timeout, restart, relock and reset
module tb_delay_aligner;
  localparam int NB = 2, CW = 4, MD = 15;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [NB:0] ref_in = '0, dly_in, ref_out;
  logic [NB:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
  logic [CW-1:0] latency;
  logic locked, timeout, misalign;
  int sel = 3;
  int checks = 0, failures = 0;
  delay_aligner #(.Nbits(NB), .CNT_W(CW), .MAX_DLY(MD)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ref_in(ref_in),
    .dly_in(dly_in),
    .ref_out(ref_out),
    .latency(latency),
    .locked(locked),
    .timeout(timeout),
    .misalign(misalign)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= ref_in;
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
  end
  always_comb
    dly_in = sel == 1 ? p1 : sel == 3 ? p3 : sel == 4 ? p4 : '0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ref_in = ref_in + 1'b1;
  endtask
  initial begin
    logic [NB:0] e;
    tick();
    tick();
    chk("rst_ref_out", ref_out, 0);
    chk("rst_latency", latency, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_misalign", misalign, 0);
    rst = 1'b0;
    tick();
    ref_in = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("l3_locked_k", locked, 0);
    tick();
    chk("l3_locked_k1", locked, 0);
    tick();
    chk("l3_locked_k2", locked, 0);
    tick();
    chk("l3_locked_k3", locked, 1);
    chk("l3_latency", latency, 3);
    for (int i = 0; i < 8; i++) begin
      e = ref_in - 3'd3;
      chk("l3_ref_out", ref_out, e);
      chk("l3_ref_vs_dly", ref_out, dly_in);
      chk("l3_misalign", misalign, 0);
      tick();
    end
    sel = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("l1_misalign_clr", misalign, 0);
    chk("l1_locked_k", locked, 0);
    tick();
    chk("l1_locked", locked, 1);
    chk("l1_latency", latency, 1);
    for (int i = 0; i < 6; i++) begin
      e = ref_in - 3'd1;
      chk("l1_ref_out", ref_out, e);
      chk("l1_misalign", misalign, 0);
      tick();
    end
    sel = 0;
    ref_in = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to_timeout_%0d", i), timeout, (i == MD) ? 1 : 0);
      chk("to_locked", locked, 0);
      chk("to_ref_out", ref_out, 0);
    end
    chk("to_latency_kept", latency, 1);
    sel = 3;
    ref_in = 3'd1;
    tick();
    ref_in = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ref_in = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rs_locked_k1", locked, 0);
    tick();
    chk("rs_locked_k2", locked, 0);
    tick();
    chk("rs_locked_k3", locked, 1);
    chk("rs_latency", latency, 3);
    chk("rs_ref_vs_dly", ref_out, dly_in);
    tick();
    tick();
    chk("ma_pre", misalign, 0);
    sel = 4;
    tick();
    chk("ma_set", misalign, 1);
    tick();
    chk("ma_hold", misalign, 1);
    e = ref_in - 3'd3;
    chk("ma_ref_out", ref_out, e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("l4_misalign_clr", misalign, 0);
    chk("l4_locked_clr", locked, 0);
    chk("l4_ref_out_zero", ref_out, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("l4_locked_pre", locked, 0);
    end
    tick();
    chk("l4_locked", locked, 1);
    chk("l4_latency", latency, 4);
    for (int i = 0; i < 5; i++) begin
      e = ref_in - 3'd4;
      chk("l4_ref_out", ref_out, e);
      tick();
      chk("l4_misalign", misalign, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rl_ref_out", ref_out, 0);
    chk("rl_latency", latency, 0);
    chk("rl_locked", locked, 0);
    chk("rl_timeout", timeout, 0);
    chk("rl_misalign", misalign, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rl_idle_timeout", timeout, 0);
      chk("rl_idle_locked", locked, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
